// File: rtl/tap_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : tap_ctrl_multi
// Brief    : IEEE 1149.1 TAP controller with one-hot DR chain select and an
//            optional 32-bit IDCODE register enabled by macro TAP_IDCODE_EN.
// Revision : 1.0
// ============================================================================
module tap_ctrl_multi #(
    parameter int                  IR_WIDTH   = 4,
    parameter int                  NUM_CHAINS = 3,
    parameter logic [IR_WIDTH-1:0] IDCODE_OP  = IR_WIDTH'(4'hE),
    parameter logic [31:0]         IDCODE_VAL = 32'h1000_0001
) (
    input  logic                  TCK,
    input  logic                  TRST_b,
    input  logic                  TMS,
    input  logic                  TDI,
    output logic                  TDO,
    output logic                  tdo_en,
    input  logic [NUM_CHAINS-1:0] chain_tdo,
    output logic [NUM_CHAINS-1:0] chain_sel,
    output logic                  capture_dr,
    output logic                  shift_dr,
    output logic                  update_dr,
    output logic [IR_WIDTH-1:0]   ir_q,
    output logic [3:0]            tap_state
);

    typedef enum logic [3:0] {
        S_TLR     = 4'hF,
        S_RTI     = 4'hC,
        S_SEL_DR  = 4'h7,
        S_CAP_DR  = 4'h6,
        S_SH_DR   = 4'h2,
        S_EX1_DR  = 4'h1,
        S_PAU_DR  = 4'h3,
        S_EX2_DR  = 4'h0,
        S_UPD_DR  = 4'h5,
        S_SEL_IR  = 4'h4,
        S_CAP_IR  = 4'hE,
        S_SH_IR   = 4'hA,
        S_EX1_IR  = 4'h9,
        S_PAU_IR  = 4'hB,
        S_EX2_IR  = 4'h8,
        S_UPD_IR  = 4'hD
    } tap_state_t;

`ifdef TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] c_default_ir = IDCODE_OP;
`else
    localparam logic [IR_WIDTH-1:0] c_default_ir = '1;
`endif

    tap_state_t            r_state;
    logic [IR_WIDTH-1:0]   r_ir_sr;
    logic [IR_WIDTH-1:0]   r_ir_q;
    logic                  r_bypass;
    logic                  r_tdo;
    logic                  r_tdo_en;
    logic                  w_idcode_sel;
    logic                  w_idcode_bit;
    logic                  w_chain_active;
    logic                  w_dr_tdo;

    always_ff @(posedge TCK or negedge TRST_b) begin
        if (!TRST_b) begin
            r_state <= S_TLR;
        end else begin
            case (r_state)
                S_TLR:    r_state <= TMS ? S_TLR    : S_RTI;
                S_RTI:    r_state <= TMS ? S_SEL_DR : S_RTI;
                S_SEL_DR: r_state <= TMS ? S_SEL_IR : S_CAP_DR;
                S_CAP_DR: r_state <= TMS ? S_EX1_DR : S_SH_DR;
                S_SH_DR:  r_state <= TMS ? S_EX1_DR : S_SH_DR;
                S_EX1_DR: r_state <= TMS ? S_UPD_DR : S_PAU_DR;
                S_PAU_DR: r_state <= TMS ? S_EX2_DR : S_PAU_DR;
                S_EX2_DR: r_state <= TMS ? S_UPD_DR : S_SH_DR;
                S_UPD_DR: r_state <= TMS ? S_SEL_DR : S_RTI;
                S_SEL_IR: r_state <= TMS ? S_TLR    : S_CAP_IR;
                S_CAP_IR: r_state <= TMS ? S_EX1_IR : S_SH_IR;
                S_SH_IR:  r_state <= TMS ? S_EX1_IR : S_SH_IR;
                S_EX1_IR: r_state <= TMS ? S_UPD_IR : S_PAU_IR;
                S_PAU_IR: r_state <= TMS ? S_EX2_IR : S_PAU_IR;
                S_EX2_IR: r_state <= TMS ? S_UPD_IR : S_SH_IR;
                S_UPD_IR: r_state <= TMS ? S_SEL_DR : S_RTI;
                default:  r_state <= S_TLR;
            endcase
        end
    end

    assign tap_state = r_state;

    // IR shift register; Pause/Exit states simply hold it
    always_ff @(posedge TCK or negedge TRST_b) begin
        if (!TRST_b) begin
            r_ir_sr <= c_default_ir;
        end else begin
            case (r_state)
                S_TLR:    r_ir_sr <= c_default_ir;
                S_CAP_IR: r_ir_sr <= IR_WIDTH'(2'b01);
                S_SH_IR:  r_ir_sr <= {TDI, r_ir_sr[IR_WIDTH-1:1]};
                default:  ;
            endcase
        end
    end

    always_ff @(posedge TCK or negedge TRST_b) begin
        if (!TRST_b) begin
            r_bypass <= 1'b0;
        end else begin
            case (r_state)
                S_TLR:    r_bypass <= 1'b0;
                S_CAP_DR: r_bypass <= 1'b0;
                S_SH_DR:  r_bypass <= TDI;
                default:  ;
            endcase
        end
    end

`ifdef TAP_IDCODE_EN
    logic [31:0] r_idcode_sr;

    always_ff @(posedge TCK or negedge TRST_b) begin
        if (!TRST_b) begin
            r_idcode_sr <= IDCODE_VAL;
        end else begin
            case (r_state)
                S_CAP_DR: r_idcode_sr <= IDCODE_VAL;
                S_SH_DR:  r_idcode_sr <= {TDI, r_idcode_sr[31:1]};
                default:  ;
            endcase
        end
    end

    assign w_idcode_sel = (r_ir_q == IDCODE_OP);
    assign w_idcode_bit = r_idcode_sr[0];
`else
    logic w_unused_idcode_cfg;
    assign w_unused_idcode_cfg = ^{IDCODE_OP, IDCODE_VAL};
    assign w_idcode_sel        = 1'b0;
    assign w_idcode_bit        = 1'b0;
`endif

    for (genvar k = 0; k < NUM_CHAINS; k++) begin : g_chain_sel
        assign chain_sel[k] = (r_ir_q == IR_WIDTH'(k));
    end

    assign w_chain_active = |chain_sel;
    assign capture_dr     = (r_state == S_CAP_DR) && w_chain_active;
    assign shift_dr       = (r_state == S_SH_DR)  && w_chain_active;
    assign update_dr      = (r_state == S_UPD_DR) && w_chain_active;

    always_comb begin
        w_dr_tdo = r_bypass;
        if (w_chain_active) begin
            w_dr_tdo = |(chain_tdo & chain_sel);
        end else if (w_idcode_sel) begin
            w_dr_tdo = w_idcode_bit;
        end
    end

    // Falling-edge side: TDO/tdo_en and the active instruction
    always_ff @(negedge TCK or negedge TRST_b) begin
        if (!TRST_b) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
            r_ir_q   <= c_default_ir;
        end else begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
            case (r_state)
                S_SH_IR: begin
                    r_tdo    <= r_ir_sr[0];
                    r_tdo_en <= 1'b1;
                end
                S_SH_DR: begin
                    r_tdo    <= w_dr_tdo;
                    r_tdo_en <= 1'b1;
                end
                S_UPD_IR: r_ir_q <= r_ir_sr;
                S_TLR:    r_ir_q <= c_default_ir;
                default:  ;
            endcase
        end
    end

    assign TDO    = r_tdo;
    assign tdo_en = r_tdo_en;
    assign ir_q   = r_ir_q;

endmodule
`default_nettype wire

// File: tb/tb_tap_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_tap_ctrl_multi
// Brief    : Directed self-checking bench for tap_ctrl_multi (IR_WIDTH=4, 3 chains).
// Revision : 1.0
// ============================================================================
module tb_tap_ctrl_multi;

    logic       TCK;
    logic       TRST_b;
    logic       TMS;
    logic       TDI;
    logic       TDO;
    logic       tdo_en;
    logic [2:0] chain_tdo;
    logic [2:0] chain_sel;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic [3:0] ir_q;
    logic [3:0] tap_state;

    int checks   = 0;
    int failures = 0;

`ifdef TAP_IDCODE_EN
    localparam logic [3:0] c_def_ir = 4'hE;
`else
    localparam logic [3:0] c_def_ir = 4'hF;
`endif

    tap_ctrl_multi #(
        .IR_WIDTH   (4),
        .NUM_CHAINS (3),
        .IDCODE_OP  (4'hE),
        .IDCODE_VAL (32'h1000_0001)
    ) dut (
        .TCK        (TCK),
        .TRST_b     (TRST_b),
        .TMS        (TMS),
        .TDI        (TDI),
        .TDO        (TDO),
        .tdo_en     (tdo_en),
        .chain_tdo  (chain_tdo),
        .chain_sel  (chain_sel),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .ir_q       (ir_q),
        .tap_state  (tap_state)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One TCK: drive inputs, clock, then settle past the falling edge
    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #1;
    endtask

    // From RTI, load an instruction and return to RTI
    task automatic ir_scan(input logic [3:0] val);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(i == 3, val[i]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    logic [7:0]  pat;
    logic [31:0] idv;
    logic        bit_v;

    initial begin
        TRST_b    = 1'b0;
        TMS       = 1'b1;
        TDI       = 1'b0;
        chain_tdo = 3'b000;
        #12;
        chk("rst_state",  32'(tap_state), 32'hF);
        chk("rst_tdo",    32'(TDO),       32'h0);
        chk("rst_tdo_en", 32'(tdo_en),    32'h0);
        chk("rst_sel",    32'(chain_sel), 32'h0);
        chk("rst_ir_q",   32'(ir_q),      32'(c_def_ir));
        TRST_b = 1'b1;
        step(1'b1, 1'b0);
        chk("tlr_hold", 32'(tap_state), 32'hF);
        step(1'b0, 1'b0);
        chk("rti", 32'(tap_state), 32'hC);

        // IR scan of 4'b0001, observing the capture pattern on TDO
        step(1'b1, 1'b0);
        chk("sel_dr", 32'(tap_state), 32'h7);
        step(1'b1, 1'b0);
        chk("sel_ir", 32'(tap_state), 32'h4);
        step(1'b0, 1'b0);
        chk("cap_ir", 32'(tap_state), 32'hE);
        step(1'b0, 1'b0);
        chk("sh_ir_state", 32'(tap_state), 32'hA);
        chk("ir_tdo0", 32'(TDO), 32'h1);
        chk("ir_en0",  32'(tdo_en), 32'h1);
        step(1'b0, 1'b1);
        chk("ir_tdo1", 32'(TDO), 32'h0);
        step(1'b0, 1'b0);
        chk("ir_tdo2", 32'(TDO), 32'h0);
        step(1'b0, 1'b0);
        chk("ir_tdo3", 32'(TDO), 32'h0);
        step(1'b1, 1'b0);
        chk("ex1_ir", 32'(tap_state), 32'h9);
        chk("ex1_ir_en", 32'(tdo_en), 32'h0);
        chk("ir_q_hold", 32'(ir_q), 32'(c_def_ir));
        step(1'b1, 1'b0);
        chk("upd_ir", 32'(tap_state), 32'hD);
        chk("ir_q_1", 32'(ir_q), 32'h1);
        chk("sel_1", 32'(chain_sel), 32'h2);
        chk("upd_ir_no_upd_dr", 32'(update_dr), 32'h0);
        step(1'b0, 1'b0);

        // Chain 2: TDO follows chain_tdo[2], pause and resume without recapture
        ir_scan(4'h2);
        chk("ir_q_2", 32'(ir_q), 32'h2);
        chk("sel_2", 32'(chain_sel), 32'h4);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("cap_dr", 32'(tap_state), 32'h6);
        chk("cap_dr_strobe", 32'(capture_dr), 32'h1);
        for (int i = 0; i < 10; i++) begin
            bit_v     = i[0];
            chain_tdo = {bit_v, ~bit_v, ~bit_v};
            step(1'b0, 1'b0);
            chk("ch_state", 32'(tap_state), 32'h2);
            chk("ch_shift", 32'(shift_dr), 32'h1);
            chk("ch_tdo", 32'(TDO), 32'(bit_v));
        end
        step(1'b1, 1'b0);
        chk("ex1_dr", 32'(tap_state), 32'h1);
        chk("ex1_dr_tdo_en", 32'(tdo_en), 32'h0);
        chk("ex1_dr_tdo", 32'(TDO), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            chk("pau_dr", 32'(tap_state), 32'h3);
            chk("pau_shift", 32'(shift_dr), 32'h0);
        end
        step(1'b1, 1'b0);
        chk("ex2_dr", 32'(tap_state), 32'h0);
        chain_tdo = 3'b100;
        step(1'b0, 1'b0);
        chk("resume_state", 32'(tap_state), 32'h2);
        chk("resume_cap", 32'(capture_dr), 32'h0);
        chk("resume_tdo", 32'(TDO), 32'h1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("upd_dr", 32'(tap_state), 32'h5);
        chk("upd_dr_strobe", 32'(update_dr), 32'h1);
        step(1'b0, 1'b0);
        chk("upd_dr_done", 32'(update_dr), 32'h0);
        chain_tdo = 3'b000;

        // Bypass: 8'hA5 comes back one TCK late after a leading 0
        ir_scan(4'hF);
        chk("ir_q_f", 32'(ir_q), 32'hF);
        chk("sel_f", 32'(chain_sel), 32'h0);
        pat = 8'hA5;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("byp_cap_strobe", 32'(capture_dr), 32'h0);
        chain_tdo = 3'b111;
        step(1'b0, 1'b0);
        chk("byp_first", 32'(TDO), 32'h0);
        chk("byp_shift_strobe", 32'(shift_dr), 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, pat[i]);
            chk("byp_tdo", 32'(TDO), 32'(pat[i]));
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("byp_upd_strobe", 32'(update_dr), 32'h0);
        step(1'b0, 1'b0);
        chain_tdo = 3'b000;

        // Asynchronous reset in the middle of a chain shift
        ir_scan(4'h2);
        chain_tdo = 3'b100;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("pre_trst_en", 32'(tdo_en), 32'h1);
        chk("pre_trst_tdo", 32'(TDO), 32'h1);
        TRST_b = 1'b0;
        #2;
        chk("trst_state", 32'(tap_state), 32'hF);
        chk("trst_tdo", 32'(TDO), 32'h0);
        chk("trst_en", 32'(tdo_en), 32'h0);
        chk("trst_sel", 32'(chain_sel), 32'h0);
        chk("trst_ir_q", 32'(ir_q), 32'(c_def_ir));
        TRST_b    = 1'b1;
        chain_tdo = 3'b000;

        // Five TMS=1 clocks from Pause-IR reach TLR and restore the default IR
        step(1'b0, 1'b0);
        ir_scan(4'h1);
        chk("ir_q_1b", 32'(ir_q), 32'h1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("pau_ir", 32'(tap_state), 32'hB);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("tms5_state", 32'(tap_state), 32'hF);
        chk("tms5_ir_q", 32'(ir_q), 32'(c_def_ir));
        chk("tms5_sel", 32'(chain_sel), 32'h0);

        // Default instruction DR scan: IDCODE with the macro, bypass without
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
`ifdef TAP_IDCODE_EN
        idv = 32'h1000_0001;
        chk("id_bit0", 32'(TDO), 32'(idv[0]));
        for (int i = 1; i < 32; i++) begin
            step(1'b0, 1'b0);
            chk("id_bit", 32'(TDO), 32'(idv[i]));
        end
`else
        idv = 32'h0;
        chk("def_first", 32'(TDO), 32'(idv[0]));
        step(1'b0, 1'b1);
        chk("def_byp1", 32'(TDO), 32'h1);
        step(1'b0, 1'b0);
        chk("def_byp0", 32'(TDO), 32'h0);
`endif
        step(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
